tx_symbol_source: RTL and testbench

Transmit-side symbol source for the 16-QAM modem. It runs on one system clock and contains three parts:
- a 4-bit phase counter that produces the sample-rate and symbol-rate clock enables;
- a maximal-length Fibonacci LFSR that supplies 4-bit symbols, with period markers;
- a Gray-coded 16-QAM mapper that produces registered 18-bit signed I/Q levels.

It feeds the upsampler and the SRRC transmit filter.

---
 rtl/tx_symbol_source_pkg.sv | 34 +++
 rtl/tx_symbol_source_if.sv | 31 +++
 rtl/tx_symbol_source_lfsr_core.sv | 75 +++++++
 rtl/tx_symbol_source.sv | 82 ++++++++
 tb/tb_tx_symbol_source.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/tx_symbol_source_pkg.sv
// Shared constants and the Gray-coded 16-QAM level function for the transmit symbol source.
package tx_symbol_source_pkg;

  localparam int LFSR_LEN_DEF = 22;
  localparam int OUT_W_DEF    = 18;

  // Levels at the 18-bit 1s17 output width: +-a and +-3a with a = 2^15
  localparam int QAM_LVL_HI = 98304;
  localparam int QAM_LVL_LO = 32768;

  // Gray map of one axis: 00 -> -3a, 01 -> -a, 11 -> +a, 10 -> +3a (a scaled to out_w)
  function automatic int qam_gray_level(input logic [1:0] bits, input int out_w);
    int lo;
    int hi;
    int lvl;
    if (out_w >= 18) begin
      lo = QAM_LVL_LO << (out_w - 18);
      hi = QAM_LVL_HI << (out_w - 18);
    end else begin
      lo = QAM_LVL_LO >> (18 - out_w);
      hi = QAM_LVL_HI >> (18 - out_w);
    end
    lvl = 0;
    case (bits)
      2'b00: lvl = -hi;
      2'b01: lvl = -lo;
      2'b11: lvl = lo;
      2'b10: lvl = hi;
      default: lvl = 0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/tx_symbol_source_if.sv
// Output bundle of the transmit symbol source toward the upsampler / SRRC filter.
// sample_en and sym_en are single-cycle strobes with no backpressure: the consumer must take data on the strobe.
interface tx_symbol_source_if #(
  parameter int LFSR_LEN = 22,
  parameter int OUT_W    = 18
);
  logic [3:0]                 phase;
  logic                       sample_en;
  logic                       sym_en;
  logic [LFSR_LEN-1:0]        seq_out;
  logic [3:0]                 sym_out;
  logic                       cycle_out;
  logic                       cycle_out_periodic;
  logic                       cycle_out_periodic_ahead;
  logic                       cycle_out_periodic_behind;
  logic [LFSR_LEN-1:0]        lfsr_counter;
  logic signed [OUT_W-1:0]    in_phs_sig;
  logic signed [OUT_W-1:0]    quad_sig;

  modport master (
    output phase, sample_en, sym_en, seq_out, sym_out, cycle_out,
           cycle_out_periodic, cycle_out_periodic_ahead, cycle_out_periodic_behind,
           lfsr_counter, in_phs_sig, quad_sig
  );

  modport slave (
    input  phase, sample_en, sym_en, seq_out, sym_out, cycle_out,
           cycle_out_periodic, cycle_out_periodic_ahead, cycle_out_periodic_behind,
           lfsr_counter, in_phs_sig, quad_sig
  );
endinterface

// File: rtl/tx_symbol_source_lfsr_core.sv
// Fibonacci LFSR with a period counter and registered period markers; advances only when en is high.
// Counter and periodic markers exist only when TX_PERIOD_MARKERS_EN is defined.
module tx_lfsr_core #(
  parameter int                  LFSR_LEN = 22,
  parameter logic [LFSR_LEN-1:0] TAPS     = LFSR_LEN'(22'h300000),
  parameter logic [LFSR_LEN-1:0] SEED     = {LFSR_LEN{1'b1}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  output logic [LFSR_LEN-1:0] state,
  output logic [LFSR_LEN-1:0] counter,
  output logic                cycle_out,
  output logic                periodic,
  output logic                periodic_ahead,
  output logic                periodic_behind
);

  logic                fb;
  logic [LFSR_LEN-1:0] state_next;

  assign fb         = ^(state & TAPS);
  assign state_next = {state[LFSR_LEN-2:0], fb};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEED;
      cycle_out <= 1'b0;
    end else begin
      cycle_out <= 1'b0;
      if (en) begin
        state     <= state_next;
        cycle_out <= (state_next == SEED);
      end
    end
  end

`ifdef TX_PERIOD_MARKERS_EN
  // Counter runs 0 .. 2^LEN-2, matching the LFSR period of 2^LEN-1 symbols
  localparam logic [LFSR_LEN-1:0] CNT_LAST = {{(LFSR_LEN-1){1'b1}}, 1'b0};
  localparam logic [LFSR_LEN-1:0] CNT_ONE  = {{(LFSR_LEN-1){1'b0}}, 1'b1};

  logic [LFSR_LEN-1:0] cnt_q;
  logic [LFSR_LEN-1:0] cnt_next;

  assign cnt_next = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q           <= '0;
      periodic        <= 1'b0;
      periodic_ahead  <= 1'b0;
      periodic_behind <= 1'b0;
    end else begin
      periodic        <= 1'b0;
      periodic_ahead  <= 1'b0;
      periodic_behind <= 1'b0;
      if (en) begin
        cnt_q           <= cnt_next;
        periodic        <= (cnt_next == '0);
        periodic_ahead  <= (cnt_next == CNT_LAST);
        periodic_behind <= (cnt_next == CNT_ONE);
      end
    end
  end

  assign counter = cnt_q;
`else
  assign counter         = '0;
  assign periodic        = 1'b0;
  assign periodic_ahead  = 1'b0;
  assign periodic_behind = 1'b0;
`endif

endmodule

// File: rtl/tx_symbol_source.sv
// 16-QAM transmit symbol source: phase counter strobes, LFSR symbols and registered Gray-mapped I/Q.
// Optional period counter/markers enabled by defining TX_PERIOD_MARKERS_EN.
module tx_symbol_source
  import tx_symbol_source_pkg::*;
#(
  parameter int                  LFSR_LEN = LFSR_LEN_DEF,
  parameter logic [LFSR_LEN-1:0] TAPS     = LFSR_LEN'(22'h300000),
  parameter logic [LFSR_LEN-1:0] SEED     = {LFSR_LEN{1'b1}},
  parameter int                  OUT_W    = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  tx_symbol_source_if.master sym_if
);

  logic [3:0]              phase;
  logic                    sample_en;
  logic                    sym_en;
  logic [LFSR_LEN-1:0]     seq;
  logic [LFSR_LEN-1:0]     counter;
  logic                    cycle_out;
  logic                    periodic;
  logic                    periodic_ahead;
  logic                    periodic_behind;
  logic [3:0]              sym;
  logic signed [OUT_W-1:0] i_lvl;
  logic signed [OUT_W-1:0] q_lvl;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 4'd0;
    end else begin
      phase <= phase + 4'd1;
    end
  end

  assign sample_en = &phase[1:0];
  assign sym_en    = &phase;

  tx_lfsr_core #(
    .LFSR_LEN (LFSR_LEN),
    .TAPS     (TAPS),
    .SEED     (SEED)
  ) u_core (
    .clk             (clk),
    .reset           (reset),
    .en              (sym_en),
    .state           (seq),
    .counter         (counter),
    .cycle_out       (cycle_out),
    .periodic        (periodic),
    .periodic_ahead  (periodic_ahead),
    .periodic_behind (periodic_behind)
  );

  assign sym = seq[3:0];

  // Mapped from the pre-shift symbol, so I/Q lag sym_out by one symbol
  always_ff @(posedge clk) begin
    if (reset) begin
      i_lvl <= '0;
      q_lvl <= '0;
    end else if (sym_en) begin
      i_lvl <= OUT_W'(qam_gray_level(sym[3:2], OUT_W));
      q_lvl <= OUT_W'(qam_gray_level(sym[1:0], OUT_W));
    end
  end

  assign sym_if.phase                     = phase;
  assign sym_if.sample_en                 = sample_en;
  assign sym_if.sym_en                    = sym_en;
  assign sym_if.seq_out                   = seq;
  assign sym_if.sym_out                   = sym;
  assign sym_if.cycle_out                 = cycle_out;
  assign sym_if.cycle_out_periodic        = periodic;
  assign sym_if.cycle_out_periodic_ahead  = periodic_ahead;
  assign sym_if.cycle_out_periodic_behind = periodic_behind;
  assign sym_if.lfsr_counter              = counter;
  assign sym_if.in_phs_sig                = i_lvl;
  assign sym_if.quad_sig                  = q_lvl;

endmodule

// File: tb/tb_tx_symbol_source.sv
// Bench for tx_symbol_source: a 4-bit LFSR instance pinned by the known sequence and a default 22-bit instance.
module tb_tx_symbol_source;

`ifdef TX_PERIOD_MARKERS_EN
  localparam bit MK = 1'b1;
`else
  localparam bit MK = 1'b0;
`endif
  localparam int      P_S    = 15;
  localparam longint  P_D    = 64'd4194303;
  localparam logic [21:0] SEED_D = 22'h3FFFFF;

  // ---------------- clock / reset ----------------
  logic clk_25 = 1'b0;
  logic reset  = 1'b1;
  always #20 clk_25 = ~clk_25;

  tx_symbol_source_if #(.LFSR_LEN(4),  .OUT_W(18)) if_s ();
  tx_symbol_source_if #(.LFSR_LEN(22), .OUT_W(18)) if_d ();

  tx_symbol_source #(.LFSR_LEN(4), .TAPS(4'b1100), .SEED(4'hF), .OUT_W(18)) dut_s (
    .clk (clk_25), .reset (reset), .sym_if (if_s)
  );
  tx_symbol_source dut_d (
    .clk (clk_25), .reset (reset), .sym_if (if_d)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] seq_tbl [P_S] = '{4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3,
                                4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF};

  function automatic logic [3:0] small_seq(input int n);
    return (n == 0) ? 4'hF : seq_tbl[(n - 1) % P_S];
  endfunction

  function automatic int level(input logic [1:0] b);
    case (b)
      2'b00:   return -98304;
      2'b01:   return -32768;
      2'b11:   return 32768;
      default: return 98304;
    endcase
  endfunction

  function automatic logic [21:0] step22(input logic [21:0] s);
    return {s[20:0], s[21] ^ s[20]};
  endfunction

  bit          model_ok = 1'b0;
  int          cyc      = 0;
  int          k        = 0;
  bit          stepped  = 1'b0;
  logic [21:0] d_state  = SEED_D;
  logic [21:0] d_prev   = SEED_D;
  logic [21:0] exp_q[$];

  always @(posedge clk_25) begin
    if (reset) begin
      model_ok = 1'b1;
      cyc = 0; k = 0; stepped = 1'b0;
      d_state = SEED_D; d_prev = SEED_D;
      exp_q.delete();
    end else begin
      stepped = (cyc % 16 == 15);
      if (stepped) begin
        k++;
        d_prev  = d_state;
        d_state = step22(d_state);
        exp_q.push_back(d_state);
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [15:0] seen_d  = '0;
  int          zero_hits = 0;

  always @(negedge clk_25) begin
    if (model_ok) begin
      int ph;
      int cs;
      longint cd;
      logic [3:0] pre;
      ph = cyc % 16;
      cs = k % P_S;
      cd = longint'(k) % P_D;
      pre = small_seq((k > 0) ? k - 1 : 0);
      check("phase_s",  if_s.phase, ph);
      check("phase_d",  if_d.phase, ph);
      check("sample_en", if_s.sample_en, (ph % 4 == 3));
      check("sym_en",   if_s.sym_en, (ph == 15));
      check("seq_s",    if_s.seq_out, small_seq(k));
      check("sym_s",    if_s.sym_out, small_seq(k));
      check("i_s", int'(if_s.in_phs_sig), (k > 0) ? level(pre[3:2]) : 0);
      check("q_s", int'(if_s.quad_sig),   (k > 0) ? level(pre[1:0]) : 0);
      check("cyc_s",    if_s.cycle_out, stepped && (small_seq(k) == 4'hF));
      check("cnt_s",    if_s.lfsr_counter, MK ? cs : 0);
      check("per_s",    if_s.cycle_out_periodic,        MK && stepped && (cs == 0));
      check("ahead_s",  if_s.cycle_out_periodic_ahead,  MK && stepped && (cs == P_S - 1));
      check("behind_s", if_s.cycle_out_periodic_behind, MK && stepped && (cs == 1));
      check("seq_d",    if_d.seq_out, d_state);
      check("i_d", int'(if_d.in_phs_sig), (k > 0) ? level(d_prev[3:2]) : 0);
      check("q_d", int'(if_d.quad_sig),   (k > 0) ? level(d_prev[1:0]) : 0);
      check("cyc_d",    if_d.cycle_out, stepped && (d_state == SEED_D));
      check("cnt_d",    if_d.lfsr_counter, MK ? cd : 0);
      check("per_d",    if_d.cycle_out_periodic,        MK && stepped && (cd == 0));
      check("ahead_d",  if_d.cycle_out_periodic_ahead,  MK && stepped && (cd == P_D - 1));
      check("behind_d", if_d.cycle_out_periodic_behind, MK && stepped && (cd == 1));
      if (if_d.seq_out == '0) zero_hits++;
      seen_d[if_d.sym_out] = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk_25);
    @(negedge clk_25);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    run_cycles(3);
    reset = 1'b0;

    run_cycles(3);
    check("lit_phase3",  if_s.phase, 3);
    check("lit_smp3",    if_s.sample_en, 1);
    check("lit_sym3",    if_s.sym_en, 0);
    run_cycles(12);
    check("lit_sym15",   if_s.sym_en, 1);
    check("lit_i_pre",   int'(if_s.in_phs_sig), 0);
    run_cycles(1);
    check("lit_seq1",    if_s.seq_out, 4'hE);
    check("lit_i1",      int'(if_s.in_phs_sig), 32768);
    check("lit_q1",      int'(if_s.quad_sig), 32768);
    run_cycles(16);
    check("lit_seq2",    if_s.seq_out, 4'hC);
    check("lit_q2",      int'(if_s.quad_sig), 98304);
    run_cycles(16);
    check("lit_seq3",    if_s.seq_out, 4'h8);
    check("lit_i3",      int'(if_s.in_phs_sig), 32768);
    check("lit_q3",      int'(if_s.quad_sig), -98304);
    run_cycles(16 * 11);
    check("lit_ahead14", if_s.cycle_out_periodic_ahead, MK);
    check("lit_cnt14",   if_s.lfsr_counter, MK ? 14 : 0);
    run_cycles(16);
    check("lit_seq15",   if_s.seq_out, 4'hF);
    check("lit_cyc15",   if_s.cycle_out, 1);
    check("lit_per15",   if_s.cycle_out_periodic, MK);
    check("lit_cnt15",   if_s.lfsr_counter, 0);
    run_cycles(16);
    check("lit_seq16",   if_s.seq_out, 4'hE);
    check("lit_behind16", if_s.cycle_out_periodic_behind, MK);
    run_cycles(16 * 6);
    check("lit_cnt22",   if_s.lfsr_counter, MK ? 7 : 0);
    run_cycles(5);
    reset = 1'b1;
    run_cycles(1);
    check("lit_rst_seq",   if_s.seq_out, 4'hF);
    check("lit_rst_cnt",   if_s.lfsr_counter, 0);
    check("lit_rst_phase", if_s.phase, 0);
    check("lit_rst_i",     int'(if_s.in_phs_sig), 0);
    check("lit_rst_q",     int'(if_s.quad_sig), 0);
    check("lit_rst_seqd",  if_d.seq_out, SEED_D);
    reset = 1'b0;
    run_cycles(16);
    check("lit_restart",   if_s.seq_out, 4'hE);

    for (int r = 0; r < 4; r++) begin
      run_cycles($urandom_range(20, 400));
      reset = 1'b1;
      run_cycles($urandom_range(1, 3));
      reset = 1'b0;
    end

    run_cycles(16 * 2500);
    check("d_seq_queue_len", exp_q.size(), k);
    check("d_no_zero_state", zero_hits, 0);
    check("d_all_symbols",   seen_d, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
